// File: rtl/conf_int_mul_sched_if.sv
// Operand and result streams between the IDCT datapath and the multiplier sequencer.
interface conf_int_mul_sched_if #(
  parameter int DATA_PATH_BITWIDTH = 24
);
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_PATH_BITWIDTH-1:0] A_in;
  logic [DATA_PATH_BITWIDTH-1:0] B_in;
  logic                          res_valid;
  logic [31:0]                   res_data;

  modport master (output in_valid, A_in, B_in, input in_ready, res_valid, res_data);
  modport slave  (input in_valid, A_in, B_in, output in_ready, res_valid, res_data);
endinterface

// File: rtl/conf_int_mul_sched.sv
// Block sequencer for the configurable approximate multiplier wrapper (LOAD/ROW/COL/DRAIN).
// Optional input-stall statistics counter enabled by `define MUL_SCHED_STATS_EN.
module conf_int_mul_sched #(
  parameter int DATA_PATH_BITWIDTH = 24,
  parameter int BLOCK_SIZE         = 64,
  parameter int MUL_LATENCY        = 2
) (
  input  logic                          clk,
  input  logic                          rstP,
  input  logic                          start,
  input  logic                          apx_row,
  input  logic                          apx_col,
  conf_int_mul_sched_if.slave           io,
  output logic [DATA_PATH_BITWIDTH-1:0] A_to_mul,
  output logic [DATA_PATH_BITWIDTH-1:0] B_to_mul,
  output logic [2:0]                    state_to_mul,
  output logic [8:0]                    count0,
  output logic                          racc_to_mul,
  output logic                          rapx_to_mul,
  input  logic [31:0]                   P,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   stall_cnt
);
  localparam int DCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROW   = 3'd2,
    S_COL   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                 state, state_n;
  logic                   in_ready, accept, last, push, start_acc;
  logic                   apx_row_q, apx_col_q;
  logic [DCW-1:0]         dcnt;
  logic [MUL_LATENCY-1:0] vld_pipe;

  assign in_ready     = (state == S_LOAD) || (state == S_ROW) || (state == S_COL);
  assign io.in_ready  = in_ready;
  assign accept       = io.in_valid && in_ready;
  assign last         = (count0 == 9'(BLOCK_SIZE - 1));
  assign push         = accept && ((state == S_ROW) || (state == S_COL));
  assign start_acc    = (state == S_IDLE) && start;
  assign state_to_mul = state;
  assign busy         = (state != S_IDLE);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_LOAD;
      S_LOAD:  if (accept && last) state_n = S_ROW;
      S_ROW:   if (accept && last) state_n = S_COL;
      S_COL:   if (accept && last) state_n = S_DRAIN;
      S_DRAIN: if (dcnt == DCW'(MUL_LATENCY - 1)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstP) begin
      state       <= S_IDLE;
      count0      <= '0;
      A_to_mul    <= '0;
      B_to_mul    <= '0;
      apx_row_q   <= 1'b0;
      apx_col_q   <= 1'b0;
      dcnt        <= '0;
      vld_pipe    <= '0;
      racc_to_mul <= 1'b1;
      rapx_to_mul <= 1'b0;
      io.res_valid <= 1'b0;
      io.res_data  <= '0;
      done        <= 1'b0;
    end else begin
      state <= state_n;
      if (start_acc) begin
        apx_row_q <= apx_row;
        apx_col_q <= apx_col;
        count0    <= '0;
      end
      if (accept) begin
        A_to_mul <= io.A_in;
        B_to_mul <= io.B_in;
        count0   <= last ? 9'd0 : count0 + 9'd1;
      end
      dcnt <= (state == S_DRAIN) ? dcnt + DCW'(1) : '0;
      // Token marks an operand whose product lands on P as it leaves the pipe.
      vld_pipe     <= MUL_LATENCY'({vld_pipe, push});
      io.res_valid <= vld_pipe[MUL_LATENCY-1];
      if (vld_pipe[MUL_LATENCY-1]) io.res_data <= P;
      // Wrapper controls follow the state being entered so they align with state_to_mul.
      racc_to_mul <= (state_n == S_IDLE);
      rapx_to_mul <= (state_n == S_ROW) ? apx_row_q :
                     (state_n == S_COL) ? apx_col_q : 1'b0;
      done        <= (state == S_DRAIN) && (state_n == S_IDLE);
    end
  end

`ifdef MUL_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rstP || start_acc)
      stall_cnt <= '0;
    else if (in_ready && !io.in_valid && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conf_int_mul_sched.sv
// Directed bench for conf_int_mul_sched: checkpoint table plus hand-written block scenarios.
module tb_conf_int_mul_sched;
  localparam int BS = 64;

  logic        clk = 1'b0;
  logic        rstP, start, apx_row, apx_col;
  logic [23:0] A_to_mul, B_to_mul;
  logic [2:0]  state_to_mul;
  logic [8:0]  count0;
  logic        racc_to_mul, rapx_to_mul, busy, done;
  logic [31:0] P;
  logic [15:0] stall_cnt;
  logic [47:0] prod;

  conf_int_mul_sched_if #(.DATA_PATH_BITWIDTH(24)) ifc();

  conf_int_mul_sched #(.DATA_PATH_BITWIDTH(24), .BLOCK_SIZE(BS), .MUL_LATENCY(2)) dut (
    .clk(clk), .rstP(rstP), .start(start), .apx_row(apx_row), .apx_col(apx_col),
    .io(ifc.slave), .A_to_mul(A_to_mul), .B_to_mul(B_to_mul),
    .state_to_mul(state_to_mul), .count0(count0), .racc_to_mul(racc_to_mul),
    .rapx_to_mul(rapx_to_mul), .P(P), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Wrapper stand-in: one register stage after the sequencer's operand registers.
  assign prod = {24'd0, A_to_mul} * {24'd0, B_to_mul};
  always @(posedge clk) P <= prod[31:0];

  typedef struct {
    int         s;
    logic [2:0] st;
    logic [8:0] c0;
    logic       racc, rapx, bsy, dn, rv;
  } vec_t;

  int total = 0, bad = 0;
  logic [2:0] st_a [400];
  logic [8:0] c0_a [400];
  logic racc_a [400], rapx_a [400], busy_a [400], done_a [400], rv_a [400];
  int nres, done_cnt, done_at, first_rv, last_rv, c20_cnt, rst_s, nrv_rst;
  logic [31:0] expq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] op_a(input bit var_d, input int i);
    return var_d ? 24'(i + 1) : 24'd3;
  endfunction
  function automatic logic [23:0] op_b(input bit var_d, input int i);
    return var_d ? 24'(2 * i + 3) : 24'd5;
  endfunction

  task automatic run_block(input bit ar, input bit ac, input bit var_d, input bit stall_en,
                           input bit rst_col, input bit start_row, input bit tog);
    int pidx = 0, stall_left;
    bit acc = 0, rst_seen = 0, fin = 0;
    logic [47:0] e;
    stall_left = stall_en ? 10 : 0;
    nres = 0; done_cnt = 0; done_at = -1; first_rv = -1; last_rv = -1;
    c20_cnt = 0; rst_s = -1; nrv_rst = 0;
    expq.delete();
    start = 1'b1; apx_row = ar; apx_col = ac; ifc.in_valid = 1'b1;
    ifc.A_in = op_a(var_d, 0); ifc.B_in = op_b(var_d, 0);
    for (int s = 0; s < 400 && !fin; s++) begin
      @(posedge clk); #1;
      if (acc) pidx++;
      st_a[s] = state_to_mul; c0_a[s] = count0; racc_a[s] = racc_to_mul;
      rapx_a[s] = rapx_to_mul; busy_a[s] = busy; done_a[s] = done; rv_a[s] = ifc.res_valid;
      if (ifc.res_valid) begin
        nres++;
        if (first_rv < 0) first_rv = s;
        last_rv = s;
        if (rst_seen) nrv_rst++;
        else if (expq.size() == 0) chk("res_extra", 32'd1, 32'd0);
        else chk("res_data", ifc.res_data, expq.pop_front());
      end
      if (done) begin done_cnt++; done_at = s; end
      if (state_to_mul == 3'd2 && count0 == 9'd20) c20_cnt++;
      if (rstP) begin
        chk("rst_mid_state", 32'(state_to_mul), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_racc", 32'(racc_to_mul), 32'd1);
        chk("rst_mid_count0", 32'(count0), 32'd0);
        chk("rst_mid_rv", 32'(ifc.res_valid), 32'd0);
        rstP = 1'b0; rst_seen = 1; rst_s = s;
      end
      start = 1'b0;
      if (start_row && state_to_mul == 3'd2 && count0 == 9'd10) start = 1'b1;
      if (tog && state_to_mul == 3'd2 && count0 == 9'd5) begin apx_row = !ar; apx_col = !ac; end
      ifc.in_valid = !rst_seen;
      if (stall_left > 0 && state_to_mul == 3'd2 && count0 == 9'd20) begin
        ifc.in_valid = 1'b0; stall_left--;
      end
      if (rst_col && !rst_seen && state_to_mul == 3'd3 && count0 == 9'd30) rstP = 1'b1;
      ifc.A_in = op_a(var_d, pidx); ifc.B_in = op_b(var_d, pidx);
      acc = ifc.in_valid && ifc.in_ready && !rstP;
      if (acc && pidx >= BS) begin
        e = {24'd0, ifc.A_in} * {24'd0, ifc.B_in};
        expq.push_back(e[31:0]);
      end
      if (done_at >= 0 && s >= done_at + 2) fin = 1;
      if (rst_seen && s >= rst_s + 10) fin = 1;
    end
    ifc.in_valid = 1'b0; start = 1'b0;
    if (!fin) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vec_t tbl [12];
    int cnt [5];
    int nbad;
    tbl[0]  = '{0,   3'd1, 9'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{63,  3'd1, 9'd63, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{64,  3'd2, 9'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{66,  3'd2, 9'd2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{67,  3'd2, 9'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{127, 3'd2, 9'd63, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{128, 3'd3, 9'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{191, 3'd3, 9'd63, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{192, 3'd4, 9'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{193, 3'd4, 9'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{194, 3'd0, 9'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{195, 3'd0, 9'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rstP = 1'b1; start = 1'b0; apx_row = 1'b0; apx_col = 1'b0;
    ifc.in_valid = 1'b0; ifc.A_in = '0; ifc.B_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state_to_mul), 32'd0);
    chk("rst_racc", 32'(racc_to_mul), 32'd1);
    chk("rst_rapx", 32'(rapx_to_mul), 32'd0);
    chk("rst_count0", 32'(count0), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_res_valid", 32'(ifc.res_valid), 32'd0);
    chk("rst_res_data", ifc.res_data, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_A_B", {A_to_mul[15:0], B_to_mul[15:0]}, 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rstP = 1'b0;
    @(posedge clk); #1;

    // Block 1: constant operands 3*5, apx off
    run_block(0, 0, 0, 0, 0, 0, 0);
    cnt = '{0, 0, 0, 0, 0};
    for (int s = 0; s < done_at && s < 400; s++) if (st_a[s] < 3'd5) cnt[st_a[s]]++;
    chk("b1_load_cycles", 32'(cnt[1]), 32'd64);
    chk("b1_row_cycles", 32'(cnt[2]), 32'd64);
    chk("b1_col_cycles", 32'(cnt[3]), 32'd64);
    chk("b1_drain_cycles", 32'(cnt[4]), 32'd2);
    chk("b1_nres", 32'(nres), 32'd128);
    chk("b1_done_cnt", 32'(done_cnt), 32'd1);
    chk("b1_done_at", 32'(done_at), 32'd194);
    chk("b1_rv_gap", 32'(last_rv - first_rv + 1 - nres), 32'd0);
    chk("b1_leftover", 32'(expq.size()), 32'd0);

    // Block 2: indexed operands, apx_row=1 apx_col=0, inputs toggled mid-ROW
    run_block(1, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tbl%0d_state", tbl[i].s), 32'(st_a[tbl[i].s]), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_count0", tbl[i].s), 32'(c0_a[tbl[i].s]), 32'(tbl[i].c0));
      chk($sformatf("tbl%0d_ctl", tbl[i].s),
          {27'd0, racc_a[tbl[i].s], rapx_a[tbl[i].s], busy_a[tbl[i].s], done_a[tbl[i].s], rv_a[tbl[i].s]},
          {27'd0, tbl[i].racc, tbl[i].rapx, tbl[i].bsy, tbl[i].dn, tbl[i].rv});
    end
    nbad = 0;
    for (int s = 0; s <= done_at && s < 400; s++) begin
      if (st_a[s] == 3'd2 && rapx_a[s] !== 1'b1) nbad++;
      if (st_a[s] == 3'd3 && rapx_a[s] !== 1'b0) nbad++;
    end
    chk("b2_rapx_throughout", 32'(nbad), 32'd0);
    chk("b2_nres", 32'(nres), 32'd128);
    chk("b2_leftover", 32'(expq.size()), 32'd0);

    // Block 3: 10-cycle input stall at ROW count0=20
    run_block(0, 0, 1, 1, 0, 0, 0);
    chk("b3_hold_cycles", 32'(c20_cnt), 32'd11);
    chk("b3_done_at", 32'(done_at), 32'd204);
    chk("b3_nres", 32'(nres), 32'd128);
    chk("b3_rv_gap", 32'(last_rv - first_rv + 1 - nres), 32'd10);
`ifdef MUL_SCHED_STATS_EN
    chk("b3_stall_cnt", 32'(stall_cnt), 32'd10);
`else
    chk("b3_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // Block 4: reset at COL count0=30 aborts the block
    run_block(0, 0, 1, 0, 1, 0, 0);
    chk("b4_rst_seen", 32'(rst_s >= 0), 32'd1);
    chk("b4_done_cnt", 32'(done_cnt), 32'd0);
    chk("b4_rv_after_rst", 32'(nrv_rst), 32'd0);

    // start and rstP together: reset wins
    start = 1'b1; rstP = 1'b1;
    @(posedge clk); #1;
    chk("rst_vs_start_state", 32'(state_to_mul), 32'd0);
    chk("rst_vs_start_busy", 32'(busy), 32'd0);
    start = 1'b0; rstP = 1'b0;
    @(posedge clk); #1;
    chk("rst_vs_start_idle", 32'(state_to_mul), 32'd0);

    // Block 5: start pulsed during ROW is ignored
    run_block(0, 0, 1, 0, 0, 1, 0);
    chk("b5_done_cnt", 32'(done_cnt), 32'd1);
    chk("b5_done_at", 32'(done_at), 32'd194);
    chk("b5_nres", 32'(nres), 32'd128);
    chk("b5_idle_after", 32'(state_to_mul), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
